// File: rtl/doorbell_arbiter.sv
// Doorbell chime sequencer: latches front/back button presses, arbitrates round-robin and
// plays a timed tone pattern on the shared speaker. Define DOORBELL_GAP_EN to add the silent gap.
module doorbell_arbiter #(
  parameter int unsigned CHIME_LEN = 8,
  parameter int unsigned GAP_LEN   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_front,
  input  logic btn_back,
  output logic sel,
  output logic chime_en,
  output logic busy,
  output logic grant_front,
  output logic grant_back
);

  localparam int unsigned MaxLen = (CHIME_LEN > GAP_LEN) ? CHIME_LEN : GAP_LEN;
  localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam logic [CntW-1:0] ChimeLast = CntW'(CHIME_LEN - 1);
`ifdef DOORBELL_GAP_EN
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_LEN - 1);
`endif

  typedef enum logic [1:0] {StIdle, StToneA, StGap, StToneB} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            svc_front_q, svc_front_d;
  logic            pend_f_q, pend_b_q;
  logic            prev_f_q, prev_b_q;
  logic            press_f, press_b;
  logic            last_grant_back;
  logic            gnt_f, gnt_b;

  assign press_f = btn_front & ~prev_f_q;
  assign press_b = btn_back & ~prev_b_q;

  // svc_front holds the most recent grant, so it doubles as the round-robin pointer.
  assign last_grant_back = ~svc_front_q;

  assign gnt_f = (state_q == StIdle) & pend_f_q & (~pend_b_q | last_grant_back);
  assign gnt_b = (state_q == StIdle) & pend_b_q & ~gnt_f;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    svc_front_d = svc_front_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_f) begin
          state_d     = StToneA;
          cnt_d       = ChimeLast;
          svc_front_d = 1'b1;
        end else if (gnt_b) begin
          state_d     = StToneB;
          cnt_d       = ChimeLast;
          svc_front_d = 1'b0;
        end
      end
      StToneA: begin
        if (cnt_q == '0) begin
`ifdef DOORBELL_GAP_EN
          state_d = StGap;
          cnt_d   = GapLast;
`else
          state_d = StToneB;
          cnt_d   = ChimeLast;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StToneB;
          cnt_d   = ChimeLast;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StToneB: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      svc_front_q <= 1'b0;
      pend_f_q    <= 1'b0;
      pend_b_q    <= 1'b0;
      prev_f_q    <= 1'b1;
      prev_b_q    <= 1'b1;
      sel         <= 1'b0;
      chime_en    <= 1'b0;
      busy        <= 1'b0;
      grant_front <= 1'b0;
      grant_back  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      svc_front_q <= svc_front_d;
      prev_f_q    <= btn_front;
      prev_b_q    <= btn_back;
      pend_f_q    <= (pend_f_q & ~gnt_f) | press_f;
      pend_b_q    <= (pend_b_q & ~gnt_b) | press_b;
      sel         <= (state_d == StToneB);
      chime_en    <= (state_d == StToneA) || (state_d == StToneB);
      busy        <= (state_d != StIdle);
      grant_front <= gnt_f;
      grant_back  <= gnt_b;
    end
  end

endmodule
